v5_event_ctrl: RTL and testbench

Acquisition controller for the v5 trapezoidal shaper. It sequences the filter's reset and settling, then watches the filter output for threshold crossings. For each crossing it captures the peak amplitude over a fixed window, a timestamp and a pile-up flag. It presents one event record per valid/ready handshake to the downstream readout FIFO.

---
 rtl/package_settings.sv | 42 ++++
 rtl/v5_event_outreg.sv | 65 ++++++
 rtl/v5_event_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_v5_event_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/package_settings.sv
// -----------------------------------------------------------------------------
// package_settings
// Shared settings for the v5 acquisition controller: filter sample width,
// controller state encoding, event record layout and default timing constants.
// Optional feature macro used by the controller: V5_EVENT_BASELINE_EN.
// -----------------------------------------------------------------------------
package package_settings;

  localparam int unsigned SIZE_FILTER_DATA = 16;

  localparam int unsigned DEF_SETTLE_CYC  = 512;
  localparam int unsigned DEF_PEAK_WIN    = 32;
  localparam int unsigned DEF_HOLDOFF_CYC = 64;
  localparam int unsigned DEF_TS_W        = 32;
  localparam int unsigned DEF_BL_SHIFT    = 4;

  typedef logic signed [SIZE_FILTER_DATA-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ARMED,
    PEAK,
    HOLDOFF
  } state_t;

  // Record layout at the default timestamp width.
  typedef struct packed {
    sample_t               energy;
    logic [DEF_TS_W-1:0]   timestamp;
    logic                  pileup;
  } event_rec_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/v5_event_outreg.sv
// -----------------------------------------------------------------------------
// v5_event_outreg
// Single-entry valid/ready holding register for event records, with a
// saturating counter of records lost because the entry was still occupied.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   commit_i, rec_i : new record offered this cycle
//   ready_i         : downstream accepts the held record
//   valid_o, rec_o  : held record and its valid flag
//   drop_count_o    : saturating count of dropped records
// -----------------------------------------------------------------------------
module v5_event_outreg
  import package_settings::*;
#(
  parameter type rec_t = event_rec_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        commit_i,
  input  rec_t        rec_i,
  input  logic        ready_i,
  output logic        valid_o,
  output rec_t        rec_o,
  output logic [15:0] drop_count_o
);

  logic        valid_q, valid_d;
  rec_t        rec_q, rec_d;
  logic [15:0] drop_q, drop_d;
  logic        hs;

  always_comb begin
    hs      = valid_q && ready_i;
    valid_d = valid_q;
    rec_d   = rec_q;
    drop_d  = drop_q;
    if (commit_i) begin
      // A handshake in the same cycle frees the entry for the new record.
      if (!valid_q || hs) begin
        valid_d = 1'b1;
        rec_d   = rec_i;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (hs) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_o      = valid_q;
  assign rec_o        = rec_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/v5_event_ctrl.sv
// -----------------------------------------------------------------------------
// v5_event_ctrl
// Acquisition controller for the v5 trapezoidal shaper. Releases the filter,
// waits for it to settle, then triggers on rising threshold crossings, finds
// the peak over a fixed window, timestamps it, flags pile-up and hands one
// record per valid/ready handshake to the readout FIFO.
//   clk, reset (async, active low), enable (level)
//   filter_data, threshold : signed samples
//   filter_rst_n           : low holds the filter cleared
//   out_valid/out_ready    : record handshake
//   out_energy, out_timestamp, out_pileup : record fields
//   drop_count             : saturating count of records lost to backpressure
//   busy                   : high while in PEAK or HOLDOFF
// Optional feature: define V5_EVENT_BASELINE_EN to subtract a tracked
// baseline from the peak (adds the BL_SHIFT parameter).
// -----------------------------------------------------------------------------
module v5_event_ctrl
  import package_settings::*;
#(
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned PEAK_WIN    = DEF_PEAK_WIN,
  parameter int unsigned HOLDOFF_CYC = DEF_HOLDOFF_CYC,
  parameter int unsigned TS_W        = DEF_TS_W
`ifdef V5_EVENT_BASELINE_EN
  ,
  parameter int unsigned BL_SHIFT    = DEF_BL_SHIFT
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  output logic                               filter_rst_n,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] out_energy,
  output logic [TS_W-1:0]                    out_timestamp,
  output logic                               out_pileup,
  output logic [15:0]                        drop_count,
  output logic                               busy
);

  localparam int unsigned CNT_MAX = max3(SETTLE_CYC, PEAK_WIN, HOLDOFF_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef struct packed {
    sample_t           energy;
    logic [TS_W-1:0]   timestamp;
    logic              pileup;
  } rec_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   tscap_q, tscap_d;
  sample_t           max_q, max_d;
  logic              pile_q, pile_d;
  logic              prev_above_q;
  logic              frst_q;
  logic              above, trig, commit;
  sample_t           energy_c;
  rec_t              rec_c, rec_out;

  assign above = filter_data > threshold;
  assign trig  = above && !prev_above_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tscap_d = tscap_q;
    max_d   = max_q;
    pile_d  = pile_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = ARMED;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ARMED: begin
        if (trig) begin
          state_d = PEAK;
          tscap_d = ts_q;
          max_d   = filter_data;
          pile_d  = 1'b0;
          cnt_d   = CNT_W'(PEAK_WIN - 1);
        end
      end
      PEAK: begin
        // The counter reaches zero on the last window sample; the commit
        // happens one edge later from the registered max, so the record is
        // visible exactly PEAK_WIN cycles after the trigger edge.
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = HOLDOFF;
          cnt_d   = CNT_W'(HOLDOFF_CYC - 1);
        end else begin
          if (filter_data > max_q) max_d = filter_data;
          if (trig)                pile_d = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) state_d = ARMED;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Disable wins in every state and discards an unfinished window.
    if (!enable) begin
      state_d = IDLE;
      commit  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ts_q         <= '0;
      tscap_q      <= '0;
      max_q        <= '0;
      pile_q       <= 1'b0;
      prev_above_q <= 1'b0;
      frst_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ts_q         <= ts_q + TS_W'(1);
      tscap_q      <= tscap_d;
      max_q        <= max_d;
      pile_q       <= pile_d;
      prev_above_q <= above;
      frst_q       <= (state_d != IDLE);
    end
  end

`ifdef V5_EVENT_BASELINE_EN
  // Baseline kept with BL_SHIFT fractional bits so the IIR settles to within
  // one LSB of a constant input instead of stalling 2^BL_SHIFT-1 short.
  localparam int unsigned BL_W = SIZE_FILTER_DATA + BL_SHIFT + 1;

  logic signed [BL_W-1:0]           bl_q, bl_d;
  logic signed [BL_W:0]             fd_ext, bl_ext, bl_err;
  logic signed [BL_W-1:0]           bl_step;
  logic signed [SIZE_FILTER_DATA:0] bl_int, max_ext, e_diff;

  always_comb begin
    fd_ext  = filter_data;
    bl_ext  = bl_q;
    bl_err  = (fd_ext <<< BL_SHIFT) - bl_ext;
    bl_step = BL_W'(bl_err >>> BL_SHIFT);
    bl_d    = bl_q;
    if (state_q == IDLE && state_d == SETTLE) begin
      bl_d = '0;
    end else if (state_q == ARMED && enable && !trig) begin
      bl_d = bl_q + bl_step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bl_q <= '0;
    else        bl_q <= bl_d;
  end

  always_comb begin
    bl_int  = (SIZE_FILTER_DATA + 1)'(bl_q >>> BL_SHIFT);
    max_ext = max_q;
    e_diff  = max_ext - bl_int;
    if (e_diff < 0) begin
      energy_c = '0;
    end else if (e_diff[SIZE_FILTER_DATA] != e_diff[SIZE_FILTER_DATA-1]) begin
      energy_c = {1'b0, {(SIZE_FILTER_DATA-1){1'b1}}};
    end else begin
      energy_c = e_diff[SIZE_FILTER_DATA-1:0];
    end
  end
`else
  assign energy_c = max_q;
`endif

  always_comb begin
    rec_c           = '0;
    rec_c.energy    = energy_c;
    rec_c.timestamp = tscap_q;
    rec_c.pileup    = pile_q;
  end

  v5_event_outreg #(
    .rec_t(rec_t)
  ) u_outreg (
    .clk_i        (clk),
    .rst_ni       (reset),
    .commit_i     (commit),
    .rec_i        (rec_c),
    .ready_i      (out_ready),
    .valid_o      (out_valid),
    .rec_o        (rec_out),
    .drop_count_o (drop_count)
  );

  assign out_energy    = rec_out.energy;
  assign out_timestamp = rec_out.timestamp;
  assign out_pileup    = rec_out.pileup;
  assign filter_rst_n  = frst_q;
  assign busy          = (state_q == PEAK) || (state_q == HOLDOFF);

endmodule

// File: tb/tb_v5_event_ctrl.sv
module tb_v5_event_ctrl;
  import package_settings::*;

  localparam int    SW       = SIZE_FILTER_DATA;
  localparam int    SETTLE   = 512;
  localparam int    PWIN     = 32;
  localparam int    HOLD     = 64;
  localparam longint TSMOD   = 64'd1 << 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [SW-1:0] fd = '0;
  logic signed [SW-1:0] th = 16'sd100;

  logic                 filter_rst_n, out_valid, out_pileup, busy;
  logic signed [SW-1:0] out_energy;
  logic [31:0]          out_timestamp;
  logic [15:0]          drop_count;

  always #5 clk = ~clk;

  v5_event_ctrl #(
    .SETTLE_CYC (SETTLE),
    .PEAK_WIN   (PWIN),
    .HOLDOFF_CYC(HOLD),
    .TS_W       (32)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .enable       (enable),
    .filter_data  (fd),
    .threshold    (th),
    .filter_rst_n (filter_rst_n),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_energy   (out_energy),
    .out_timestamp(out_timestamp),
    .out_pileup   (out_pileup),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;
  int edges = 0;

  always @(posedge clk) if (rst_n) edges <= edges + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_tol(input string name, input logic signed [63:0] act,
                           input logic signed [63:0] exp, input int tol);
    total++;
    if ($isunknown(act) || act > exp + tol || act < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d +/-%0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  // ---------------- behavioural model (time-bookkeeping view) ----------------
  bit     m_run = 0;      // filter released
  int     m_settle = 0;   // settle cycles still to elapse
  int     m_win = 0;      // window samples collected so far (0 = no window)
  int     m_hold = 0;     // holdoff cycles still to elapse
  int     m_max = 0;
  bit     m_pile = 0;
  longint m_tscap = 0;
  longint m_ts = 0;
  bit     m_prev = 0;
  real    m_bl = 0.0;
  bit     e_valid = 0;
  int     e_energy = 0;
  longint e_ts = 0;
  bit     e_pile = 0;
  int     e_drop = 0;

  function automatic int model_energy(input int mx);
`ifdef V5_EVENT_BASELINE_EN
    real d;
    d = $itor(mx) - m_bl;
    if (d < 0.0) return 0;
    return int'(d);
`else
    return mx;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit above, trig, commit, hs;
    if (!rst_n) begin
      m_run = 0; m_settle = 0; m_win = 0; m_hold = 0; m_max = 0; m_pile = 0;
      m_tscap = 0; m_ts = 0; m_prev = 0; m_bl = 0.0;
      e_valid = 0; e_energy = 0; e_ts = 0; e_pile = 0; e_drop = 0;
    end else begin
      above  = fd > th;
      trig   = above && !m_prev;
      commit = 0;
      if (!enable) begin
        m_run = 0; m_win = 0; m_hold = 0;
      end else if (!m_run) begin
        m_run = 1; m_settle = SETTLE; m_bl = 0.0;
      end else if (m_settle > 0) begin
        m_settle--;
      end else if (m_win > 0) begin
        if (m_win < PWIN) begin
          if (fd > m_max) m_max = fd;
          if (trig) m_pile = 1;
          m_win++;
        end else begin
          commit = 1; m_win = 0; m_hold = HOLD;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (trig) begin
        m_win = 1; m_max = fd; m_pile = 0; m_tscap = m_ts;
      end else begin
        m_bl = m_bl + ($itor(fd) - m_bl) / (2.0 ** DEF_BL_SHIFT);
      end
      hs = e_valid && out_ready;
      if (commit) begin
        if (!e_valid || hs) begin
          e_valid = 1; e_energy = model_energy(m_max); e_ts = m_tscap; e_pile = m_pile;
        end else if (e_drop < 65535) begin
          e_drop++;
        end
      end else if (hs) begin
        e_valid = 0;
      end
      m_prev = above;
      m_ts   = (m_ts + 1) % TSMOD;
    end
  end

  always @(negedge clk) begin : compare
    check("filter_rst_n", filter_rst_n, m_run);
    check("out_valid", out_valid, e_valid);
    check("busy", busy, (m_win > 0) || (m_hold > 0));
    check("drop_count", drop_count, e_drop);
`ifdef V5_EVENT_BASELINE_EN
    check_tol("out_energy", out_energy, e_energy, 2);
`else
    check("out_energy", out_energy, e_energy);
`endif
    check("out_timestamp", out_timestamp, e_ts);
    check("out_pileup", out_pileup, e_pile);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int v);
    @(negedge clk);
    fd = SW'(v);
  endtask

  task automatic wait_valid(input string name, input int limit);
    int waited;
    waited = 0;
    while (!out_valid && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL %s: out_valid not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic check_energy_lit(input string name, input int exp);
`ifdef V5_EVENT_BASELINE_EN
    check_tol(name, out_energy, e_energy, 2);
`else
    check(name, out_energy, exp);
`endif
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int k, kd;
    step(3);
    check("rst filter_rst_n", filter_rst_n, 0);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst drop_count", drop_count, 0);
    check("rst out_energy", out_energy, 0);
    check("rst out_timestamp", out_timestamp, 0);
    check("rst out_pileup", out_pileup, 0);
    rst_n = 1'b1;

    // Settle gating: toggling crossings during SETTLE, then a sample already
    // above threshold at ARMED entry.
    @(negedge clk);
    enable = 1'b1;
    fd = 16'sd1000;
    @(negedge clk);
    check("filter_rst_n rises", filter_rst_n, 1);
    for (int i = 0; i < 250; i++) begin
      put(1000);
      put(0);
    end
    check("settle busy", busy, 0);
    repeat (100) put(1000);
    check("armed-entry busy", busy, 0);
    check("armed-entry valid", out_valid, 0);
    put(0);
    step(5);

    // Single pulse, ramp 0->500 over 10 samples then decay.
    for (int i = 1; i <= 10; i++) begin
      put(50 * i);
      if (i == 3) k = edges;
    end
    for (int i = 9; i >= 0; i--) put(50 * i);
    wait_valid("pulse", 100);
    check("pulse latency", edges - k, 33);
    check_energy_lit("pulse energy", 500);
    check("pulse timestamp", out_timestamp, k);
    check("pulse pileup", out_pileup, 0);
    step(120);

    // Pile-up: re-cross at window sample 12.
    put(200);
    k = edges;
    repeat (11) put(50);
    put(300);
    put(0);
    wait_valid("pileup", 100);
    check_energy_lit("pileup energy", 300);
    check("pileup flag", out_pileup, 1);
    check("pileup timestamp", out_timestamp, k);
    step(120);

    // Backpressure across two events.
    out_ready = 1'b0;
    put(250);
    k = edges;
    put(0);
    wait_valid("bp first", 100);
    step(120);
    put(350);
    put(0);
    step(60);
    check("bp held valid", out_valid, 1);
    check_energy_lit("bp held energy", 250);
    check("bp held timestamp", out_timestamp, k);
    check("bp drop_count", drop_count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp handshake clears", out_valid, 0);
    check("bp drop after hs", drop_count, 1);

    // Commit coinciding with a handshake.
    out_ready = 1'b0;
    step(100);
    put(120);
    put(0);
    wait_valid("coinc first", 100);
    step(120);
    put(220);
    kd = edges;
    put(0);
    while (edges < kd + 32) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("coinc valid stays", out_valid, 1);
    check_energy_lit("coinc energy", 220);
    check("coinc timestamp", out_timestamp, kd);
    check("coinc no drop", drop_count, 1);
    @(negedge clk);
    check("coinc cleared", out_valid, 0);

    // Disable during PEAK, then full re-settle.
    step(120);
    put(400);
    repeat (5) put(0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis filter_rst_n", filter_rst_n, 0);
    check("dis busy", busy, 0);
    step(50);
    check("dis no record", out_valid, 0);
    check("dis drop unchanged", drop_count, 1);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reen filter_rst_n", filter_rst_n, 1);
    step(100);
    put(300);
    put(0);
    step(5);
    check("reen settle ignores", busy, 0);
    step(500);
    put(450);
    k = edges;
    put(0);
    wait_valid("reen pulse", 100);
    check_energy_lit("reen energy", 450);
    check("reen timestamp", out_timestamp, k);
    step(120);

`ifdef V5_EVENT_BASELINE_EN
    repeat (1000) put(40);
    put(540);
    put(40);
    wait_valid("baseline pulse", 100);
    check_tol("baseline energy", out_energy, 500, 1);
    step(120);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
